// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices,
// forward-select encoding and the per-stage scoreboard entry.
package pipe_pkg;

    localparam int STG_IF = 0;
    localparam int STG_ID = 1;
    localparam int STG_EX = 2;

    localparam int FWD_RF = 0;

    // Widest register address the scoreboard stores; narrower addresses are zero-extended.
    localparam int SB_AW = 8;

    typedef struct packed {
        logic             valid;
        logic             wr;
        logic             is_load;
        logic [SB_AW-1:0] dst;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-producer search over the scoreboard for one source register.
// Reports whether a producer exists, its stage, and whether its data is usable.
module sb_match
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES       = 5,
    parameter int REG_AW           = 5,
    parameter int LOAD_READY_STAGE = 4,
    parameter int STG_W            = $clog2(NUM_STAGES)
) (
    input  logic [REG_AW-1:0] src_i,
    input  sb_entry_t         sb_i [STG_EX:NUM_STAGES-1],
    output logic              hit_o,
    output logic [STG_W-1:0]  stage_o,
    output logic              ready_o
);

    // Scan oldest to youngest so the last match written wins.
    always_comb begin
        hit_o   = 1'b0;
        stage_o = '0;
        ready_o = 1'b0;
        for (int s = NUM_STAGES - 1; s >= STG_EX; s--) begin
            if (sb_i[s].valid && sb_i[s].wr && (src_i != '0) &&
                (sb_i[s].dst == SB_AW'(src_i))) begin
                hit_o   = 1'b1;
                stage_o = STG_W'(s);
                ready_o = !sb_i[s].is_load || (s >= LOAD_READY_STAGE);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised hazard controller: registered scoreboard of in-flight destinations
// driving forwarding selects, load-use interlock, branch flush and EX-busy hold.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES       = 5,
    parameter int REG_AW           = 5,
    parameter int LOAD_READY_STAGE = 4,
    parameter int CNT_W            = 16,
    parameter int SEL_W            = $clog2(NUM_STAGES - 1)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              br_taken,
    input  logic              ex_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int STG_W = $clog2(NUM_STAGES);

    sb_entry_t sb_q [STG_EX:NUM_STAGES-1];
    sb_entry_t sb_d [STG_EX:NUM_STAGES-1];

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             a_hit, b_hit, a_ready, b_ready;
    logic [STG_W-1:0] a_stage, b_stage;
    logic             stall, flush;

    sb_match #(
        .NUM_STAGES      (NUM_STAGES),
        .REG_AW          (REG_AW),
        .LOAD_READY_STAGE(LOAD_READY_STAGE),
        .STG_W           (STG_W)
    ) u_match_rs (
        .src_i  (id_rs),
        .sb_i   (sb_q),
        .hit_o  (a_hit),
        .stage_o(a_stage),
        .ready_o(a_ready)
    );

    sb_match #(
        .NUM_STAGES      (NUM_STAGES),
        .REG_AW          (REG_AW),
        .LOAD_READY_STAGE(LOAD_READY_STAGE),
        .STG_W           (STG_W)
    ) u_match_rt (
        .src_i  (id_rt),
        .sb_i   (sb_q),
        .hit_o  (b_hit),
        .stage_o(b_stage),
        .ready_o(b_ready)
    );

    // A producer that is not ready can only be a load still short of LOAD_READY_STAGE.
    assign stall = id_valid && !ex_busy &&
                   ((id_uses_rs && a_hit && !a_ready) || (id_uses_rt && b_hit && !b_ready));
    assign flush = br_taken && !ex_busy && !stall;

    always_comb begin
        sb_d = sb_q;
        for (int s = STG_EX + 1; s < NUM_STAGES; s++) begin
            sb_d[s] = sb_q[s-1];
        end
        if (ex_busy) begin
            sb_d[STG_EX]     = sb_q[STG_EX];
            sb_d[STG_EX + 1] = '0;
        end else begin
            sb_d[STG_EX].valid   = id_valid && !stall;
            sb_d[STG_EX].wr      = id_reg_write;
            sb_d[STG_EX].is_load = id_is_load;
            sb_d[STG_EX].dst     = SB_AW'(id_rd);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int s = STG_EX; s < NUM_STAGES; s++) begin
                sb_q[s] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Outputs snap to their idle values while Reset is high, regardless of ID inputs.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a_sel   = SEL_W'(FWD_RF);
        fwd_b_sel   = SEL_W'(FWD_RF);
        if (!Reset) begin
            if (ex_busy) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (flush) begin
                ifid_flush = 1'b1;
            end
            if (a_hit && a_ready) begin
                fwd_a_sel = SEL_W'(a_stage - STG_W'(1));
            end
            if (b_hit && b_ready) begin
                fwd_b_sel = SEL_W'(b_stage - STG_W'(1));
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-step bench for pipe_hazard_ctrl; a second instance with 2-bit
// counters shares all inputs to exercise counter saturation.
module tb_pipe_hazard_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_is_load;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       br_taken, ex_busy;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
    logic [1:0]  s_fwd_a_sel, s_fwd_b_sel;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 Clock = ~Clock;

    pipe_hazard_ctrl u_dut (
        .Clock(Clock), .Reset(Reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .br_taken(br_taken), .ex_busy(ex_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(2)) u_sat (
        .Clock(Clock), .Reset(Reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
        .br_taken(br_taken), .ex_busy(ex_busy),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] rd,
                          input logic rw, input logic ld);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_uses_rs = urs;  id_uses_rt = urt;
        id_rd = rd;  id_reg_write = rw;  id_is_load = ld;
    endtask

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    // ctrl packs {pc_write, ifid_write, ifid_flush, idex_bubble}
    task automatic chk_ctrl(input string tag, input logic [3:0] exp);
        chk(tag, int'({pc_write, ifid_write, ifid_flush, idex_bubble}), int'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;  br_taken = 1'b0;  ex_busy = 1'b0;
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        @(negedge Clock);
        $display("step reset: ctrl=%b", {pc_write, ifid_write, ifid_flush, idex_bubble});
        chk_ctrl("reset_ctrl", 4'b1100);
        chk("reset_fwd_a", int'(fwd_a_sel), 0);
        chk("reset_fwd_b", int'(fwd_b_sel), 0);
        chk("reset_stall_cnt", int'(stall_cnt), 0);
        chk("reset_flush_cnt", int'(flush_cnt), 0);
        next_cycle();
        Reset = 1'b0;
        idle(1);

        // Back-to-back ALU dependency
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
        @(negedge Clock);
        $display("step add r3: fwd_a=%0d", fwd_a_sel);
        chk("alu_first_fwd_a", int'(fwd_a_sel), 0);
        next_cycle();
        set_id(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        @(negedge Clock);
        $display("step sub r3: fwd_a=%0d ctrl=%b", fwd_a_sel, {pc_write, ifid_write, ifid_flush, idex_bubble});
        chk("alu_fwd_a_ex", int'(fwd_a_sel), 1);
        chk("alu_fwd_b_none", int'(fwd_b_sel), 0);
        chk_ctrl("alu_no_stall", 4'b1100);
        next_cycle();
        set_id(1'b1, 5'd6, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        @(negedge Clock);
        $display("step use r6,r3: fwd_a=%0d fwd_b=%0d", fwd_a_sel, fwd_b_sel);
        chk("alu_fwd_a_ex2", int'(fwd_a_sel), 1);
        chk("alu_fwd_b_mem", int'(fwd_b_sel), 2);
        next_cycle();
        idle(4);

        // Load-use stall
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        @(negedge Clock);
        chk_ctrl("lw_issue_ctrl", 4'b1100);
        next_cycle();
        set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        @(negedge Clock);
        $display("step lu stall1: ctrl=%b cnt=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, stall_cnt);
        chk_ctrl("lu_stall1_ctrl", 4'b0001);
        next_cycle();
        @(negedge Clock);
        $display("step lu stall2: ctrl=%b cnt=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, stall_cnt);
        chk_ctrl("lu_stall2_ctrl", 4'b0001);
        chk("lu_stall2_cnt", int'(stall_cnt), 1);
        next_cycle();
        @(negedge Clock);
        $display("step lu release: ctrl=%b fwd_a=%0d cnt=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, fwd_a_sel, stall_cnt);
        chk_ctrl("lu_release_ctrl", 4'b1100);
        chk("lu_fwd_a_wb", int'(fwd_a_sel), 3);
        chk("lu_stall_cnt", int'(stall_cnt), 2);
        next_cycle();
        idle(4);

        // Register 0 is never a producer, even for a load
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
        next_cycle();
        set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0);
        @(negedge Clock);
        $display("step r0 reader: ctrl=%b fwd_a=%0d fwd_b=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, fwd_a_sel, fwd_b_sel);
        chk_ctrl("r0_ctrl", 4'b1100);
        chk("r0_fwd_a", int'(fwd_a_sel), 0);
        chk("r0_fwd_b", int'(fwd_b_sel), 0);
        next_cycle();
        idle(4);

        // Multi-cycle EX with a dependent instruction held in ID
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0);
        next_cycle();
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1);
        next_cycle();
        set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
        ex_busy = 1'b1;  br_taken = 1'b1;
        @(negedge Clock);
        $display("step busy1: ctrl=%b fwd_b=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, fwd_b_sel);
        chk_ctrl("busy1_ctrl", 4'b0000);
        chk("busy1_fwd_b", int'(fwd_b_sel), 2);
        next_cycle();
        br_taken = 1'b0;
        @(negedge Clock);
        $display("step busy2: ctrl=%b fwd_b=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, fwd_b_sel);
        chk_ctrl("busy2_ctrl", 4'b0000);
        chk("busy2_fwd_b", int'(fwd_b_sel), 3);
        next_cycle();
        @(negedge Clock);
        $display("step busy3: ctrl=%b fwd_b=%0d cnt=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, fwd_b_sel, stall_cnt);
        chk_ctrl("busy3_ctrl", 4'b0000);
        chk("busy3_fwd_b_bubble", int'(fwd_b_sel), 0);
        chk("busy3_stall_cnt", int'(stall_cnt), 2);
        next_cycle();
        ex_busy = 1'b0;
        @(negedge Clock);
        $display("step after busy: ctrl=%b cnt=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, stall_cnt);
        chk_ctrl("post_busy_stall1", 4'b0001);
        chk("post_busy_cnt", int'(stall_cnt), 2);
        chk("post_busy_flush_cnt", int'(flush_cnt), 0);
        next_cycle();
        @(negedge Clock);
        chk_ctrl("post_busy_stall2", 4'b0001);
        next_cycle();
        @(negedge Clock);
        $display("step busy release: fwd_a=%0d cnt=%0d", fwd_a_sel, stall_cnt);
        chk_ctrl("post_busy_release", 4'b1100);
        chk("post_busy_fwd_a", int'(fwd_a_sel), 3);
        chk("post_busy_stall_cnt", int'(stall_cnt), 4);
        chk("sat_stall_cnt_3", int'(s_stall_cnt), 3);
        next_cycle();
        idle(4);

        // Branch taken while stalled on a load
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1);
        next_cycle();
        set_id(1'b1, 5'd12, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        br_taken = 1'b1;
        @(negedge Clock);
        $display("step br stall1: ctrl=%b", {pc_write, ifid_write, ifid_flush, idex_bubble});
        chk_ctrl("br_stall1_ctrl", 4'b0001);
        next_cycle();
        @(negedge Clock);
        chk_ctrl("br_stall2_ctrl", 4'b0001);
        next_cycle();
        @(negedge Clock);
        $display("step br honoured: ctrl=%b flush_cnt=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, flush_cnt);
        chk_ctrl("br_flush_ctrl", 4'b1110);
        chk("br_flush_cnt_before", int'(flush_cnt), 0);
        next_cycle();
        br_taken = 1'b0;
        idle(1);
        @(negedge Clock);
        $display("step br done: flush_cnt=%0d stall_cnt=%0d sat=%0d", flush_cnt, stall_cnt, s_stall_cnt);
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 6);
        chk("sat_stall_cnt_hold", int'(s_stall_cnt), 3);
        chk("sat_flush_cnt", int'(s_flush_cnt), 1);
        next_cycle();
        idle(3);

        // Reset asserted in the middle of a load-use stall
        set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd13, 1'b1, 1'b1);
        next_cycle();
        set_id(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge Clock);
        chk_ctrl("rst_pre_stall", 4'b0001);
        #1;
        Reset = 1'b1;
        #1;
        $display("step mid-stall reset: ctrl=%b cnt=%0d sat=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, stall_cnt, s_stall_cnt);
        chk_ctrl("rst_now_ctrl", 4'b1100);
        chk("rst_now_stall_cnt", int'(stall_cnt), 0);
        chk("rst_now_flush_cnt", int'(flush_cnt), 0);
        chk("rst_now_sat_cnt", int'(s_stall_cnt), 0);
        next_cycle();
        Reset = 1'b0;
        @(negedge Clock);
        $display("step after reset: ctrl=%b fwd_a=%0d", {pc_write, ifid_write, ifid_flush, idex_bubble}, fwd_a_sel);
        chk_ctrl("rst_release_no_stall", 4'b1100);
        chk("rst_release_fwd_a", int'(fwd_a_sel), 0);
        chk("rst_release_cnt", int'(stall_cnt), 0);
        next_cycle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the MIPS core, replacing the separate fixed 5-stage forwarding and hazard-detection logic. It holds a registered scoreboard of in-flight destination registers for every stage from EX to the last stage. From that scoreboard it produces operand-forwarding selects, load-use interlocks, branch flushes and multi-cycle-EX holds. Stage count and load-data availability are parameters, so deeper pipelines reuse the block unchanged.

## Interface
- `NUM_STAGES`, 5, total stages. Index 0 = IF, 1 = ID, 2 = EX, ..., `NUM_STAGES-1` = WB. Minimum 4.
- `REG_AW`, 5, register address width.
- `LOAD_READY_STAGE`, 4, first stage index whose output carries valid load data. Range 3..`NUM_STAGES-1`.
- `CNT_W`, 16, width of the saturating performance counters.
- `SEL_W`, `$clog2(NUM_STAGES-1)`, forward-select width (derived; do not override).

Ports:
- `Clock`  in  1  sole clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_rs`, `id_rt`  in  `REG_AW`  source registers of the ID instruction.
- `id_uses_rs`, `id_uses_rt`  in  1  the source is actually read.
- `id_rd`  in  `REG_AW`  destination of the ID instruction.
- `id_reg_write`  in  1  the ID instruction writes `id_rd`.
- `id_is_load`  in  1  the ID instruction is a load.
- `br_taken`  in  1  branch or jump resolved taken in ID.
- `ex_busy`  in  1  multi-cycle EX unit not done; hold EX and all younger stages.
- `pc_write`  out  1  PC update enable.
- `ifid_write`  out  1  IF/ID register enable.
- `ifid_flush`  out  1  IF/ID register clear.
- `idex_bubble`  out  1  load a NOP into ID/EX.
- `fwd_a_sel`, `fwd_b_sel`  out  `SEL_W`  operand source for the ID instruction. 0 = register file; k = output of stage k+1.
- `stall_cnt`  out  `CNT_W`  load-use stall cycles, saturating.
- `flush_cnt`  out  `CNT_W`  branch flushes, saturating.

## Operation
- **Scoreboard.** One entry per stage s = 2..`NUM_STAGES-1`, each holding {valid, dst, wr, is_load}. Reset clears every entry, both counters and nothing else.
- **Advance (no hold).** Entry 2 receives the ID fields, qualified by `id_valid && !stall`. Entry s receives entry s-1.
- **`ex_busy` = 1.**
  - Entries 0..2 and ID hold.
  - Entry 3 receives an invalid bubble.
  - Entries ≥ 4 advance.
  - Outputs: `pc_write`=0, `ifid_write`=0, `idex_bubble`=0, `ifid_flush`=0.
- **Match rule.** A producer in stage s matches source r when valid && wr && dst == r && r != 0.
- **Producer selection.** The youngest match (lowest s) is the producer for r.
- **Load-use stall.** Raised when a used source has a producer that is a load with s < `LOAD_READY_STAGE`, and `id_valid` = 1 and `ex_busy` = 0. While stalled:
  - `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - Entry 2 becomes invalid.
  - `stall_cnt` increments.
- **Forwarding.**
  - Source with no producer: select = 0.
  - Source with a producer at stage s and data available: select = s-1.
  - Forwarding from stage `NUM_STAGES-1` covers the write-before-read gap at the register file.
- **Branch flush.** `br_taken` is honoured only when neither stall nor `ex_busy` is active. When honoured: `ifid_flush`=1, `pc_write`=1, `flush_cnt` increments. A stalled branch re-evaluates on the next cycle.
- **Priority.** Reset > `ex_busy` > load-use stall > `br_taken`.
- **Counters.** Both saturate at all-ones and never wrap.

## Timing
- Scoreboard and counters are registered.
- All control outputs and forward selects are combinational from the scoreboard plus same-cycle ID inputs. No output-register latency.
- Reset values: `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `idex_bubble`=0, selects=0, counters=0.
- Stall duration: exactly `LOAD_READY_STAGE`-2 cycles for a load immediately followed by a dependent instruction.
- Reset asserted mid-stall or mid-`ex_busy` clears everything at once. The first cycle after release shows no stall.

## Structure
- Shared package `pipe_pkg`:
  - stage index constants `STG_IF`, `STG_ID`, `STG_EX`;
  - the scoreboard entry struct;
  - forward-select encoding constant `FWD_RF` = 0.
- One sub-module, `sb_match`: combinational youngest-producer search for one source register, returning {hit, stage, ready}. Instantiate it twice, once for rs and once for rt.

## Test plan
- **Back-to-back ALU dependency.** `add r3` then `sub` using r3 (defaults) → `fwd_a_sel`=1 (EX output) in the `sub` ID cycle, no stall.
- **Load-use.** `lw r5` then `add` reading r5 (`LOAD_READY_STAGE`=4) → 2 cycles with `pc_write`=0 and `idex_bubble`=1, then `fwd_a_sel`=3; `stall_cnt`=2.
- **Register 0.** A producer writing r0 followed by a reader of r0 → select 0, no stall.
- **Multi-cycle EX.** `ex_busy` held for 3 cycles with a dependent instruction in ID → `pc_write`=0 for those 3 cycles, no `stall_cnt` increment, and entry 3 shows bubbles.
- **Branch interactions.** `br_taken` during a load-use stall → no flush that cycle; flush in the first unstalled cycle; `flush_cnt`=1.
- **Counter saturation and reset.** Set `CNT_W`=2 and run 5 stalls → `stall_cnt`=3. Assert `Reset` mid-stall → all outputs return to reset values immediately.
